ssd1306_stream_sequencer: RTL and testbench
===========================================

// Module: ssd1306_stream_sequencer
// PURPOSE
//  Upstream byte source for the SSD1306 SPI display path. On a start pulse it pulses the panel
//  reset, then walks a synchronous byte ROM: first INIT_LEN command bytes (DC=0), then FRAME_BYTES
//  pixel bytes (DC=1). Each byte goes to the SPI master over a ready/valid-pulse handshake.
//  The block also drives the panel RES and CS lines, so the SPI master stays a pure byte shifter.
// PARAMETERS
//  INIT_LEN        26    command bytes at ROM addresses 0..INIT_LEN-1
//  FRAME_BYTES     1024  data bytes at ROM addresses INIT_LEN..INIT_LEN+FRAME_BYTES-1
//  ROM_AW          11    ROM address width; must cover INIT_LEN+FRAME_BYTES-1
//  RES_LOW_CYCLES  16    clocks o_RES_L is held low
//  RES_WAIT_CYCLES 16    clocks after RES release before the first byte
// PORTS
//  i_Clk        in   1       clock
//  i_Rst_L      in   1       synchronous reset, active low
//  i_Start      in   1       1-cycle start request; sampled only in IDLE
//  o_Rom_Addr   out  ROM_AW  ROM address; ROM returns data 1 clock later
//  i_Rom_Data   in   8       ROM read data
//  o_TX_Byte    out  8       byte to SPI master
//  o_TX_DV      out  1       1-cycle valid pulse qualifying o_TX_Byte
//  i_TX_Ready   in   1       SPI master idle/ready for a byte
//  o_DC         out  1       0 = command, 1 = data; stable while its byte is shifted
//  o_CS_L       out  1       panel chip select, active low
//  o_RES_L      out  1       panel reset, active low
//  o_Busy       out  1       high in every state except IDLE
//  o_Done       out  1       1-cycle pulse when the sequence completes
// BEHAVIOUR
//  Reset (i_Rst_L=0 at a rising edge, in any state): FSM=IDLE; counters=0; o_Rom_Addr=0;
//    o_TX_Byte=0; o_TX_DV=0; o_DC=0; o_CS_L=1; o_RES_L=1; o_Busy=0; o_Done=0.
//    A reset mid-transfer abandons the sequence. The SPI master is reset by the same signal.
//  States:
//  - IDLE: i_Start=1 -> RES_LOW. i_Start in any other state is ignored.
//  - RES_LOW: o_RES_L=0 for exactly RES_LOW_CYCLES clocks, o_CS_L=1 -> RES_WAIT.
//  - RES_WAIT: o_RES_L=1 for RES_WAIT_CYCLES clocks. On exit set o_CS_L=0 and addr=0 -> FETCH.
//  - FETCH: drive o_Rom_Addr; set o_DC = (addr >= INIT_LEN) -> WAIT_ROM.
//  - WAIT_ROM: latch i_Rom_Data into o_TX_Byte -> SEND.
//  - SEND: when i_TX_Ready=1, o_TX_DV=1 for exactly 1 clock -> WAIT_ACK.
//    If i_TX_Ready=0, hold o_TX_Byte/o_DC and keep o_TX_DV=0.
//  - WAIT_ACK: ignore i_TX_Ready on the first clock (master drops it the clock after DV).
//    Then wait for i_TX_Ready=1. If addr == INIT_LEN+FRAME_BYTES-1 -> DONE; else addr+1 -> FETCH.
//  - DONE: o_CS_L=1, o_Done=1 for 1 clock -> IDLE.
//  Throughput: at most one byte per (3 + SPI byte time) clocks. Start-to-first-DV latency is
//    RES_LOW_CYCLES+RES_WAIT_CYCLES+3 clocks when the master is ready.
//  o_DC changes only in FETCH, never while a byte is in flight.
//  o_CS_L stays low continuously from the first byte to the last byte.
//  Counters saturate at their terminal value; no wrap occurs inside a sequence.
//  INIT_LEN=0 is legal: the first byte already has o_DC=1.
// CONFIGURATION
//  SEQ_CONTINUOUS_EN defined: after the last frame byte's ack, addr reloads to INIT_LEN.
//    The FSM goes to FETCH with o_CS_L held low, streaming frames until reset; no reset pulse and
//    no init replay. o_Done never pulses. Extra port o_Frame_Cnt (out, 16) increments on each
//    frame wrap, wraps 0xFFFF->0, and resets to 0.
//  SEQ_CONTINUOUS_EN undefined: single pass as above; o_Frame_Cnt does not exist.
// TESTING
//  1 Reset: hold i_Rst_L=0 for 3 clocks, then release -> all outputs at reset values;
//    o_CS_L=1, o_RES_L=1, o_Busy=0.
//  2 Single pass (INIT_LEN=3, FRAME_BYTES=4, RES 4/4, ROM[a]=8'hA0+a, ready always 1)
//    -> o_RES_L low exactly 4 clocks; 7 DV pulses with bytes A0..A6; o_DC 0,0,0,1,1,1,1;
//    one o_Done pulse; o_CS_L=1 after.
//  3 Backpressure: i_TX_Ready=0 for 20 clocks while in SEND -> no DV, o_TX_Byte/o_DC stable;
//    DV 1 clock after ready rises.
//  4 Start pulsed while o_Busy=1 -> ignored, exactly 7 bytes sent.
//    i_Rst_L=0 after the 2nd DV -> o_TX_DV=0, o_CS_L=1, FSM IDLE next clock.
//  5 SEQ_CONTINUOUS_EN, same params -> after byte A6 the next byte is A3 with o_DC=1;
//    o_Frame_Cnt=1; o_CS_L stays 0; no o_Done.

Source files
------------

// File: rtl/ssd1306_stream_sequencer_if.sv
// Byte path between the SSD1306 stream sequencer, its synchronous byte ROM and the SPI master.
// The master modport is the sequencer side; the slave modport is the ROM/SPI side.
interface ssd1306_stream_sequencer_if #(
  parameter int ROM_AW = 11
);
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_byte;
  logic              tx_dv;
  logic              tx_ready;
  logic              dc;

  modport master (
    output rom_addr, tx_byte, tx_dv, dc,
    input  rom_data, tx_ready
  );

  modport slave (
    input  rom_addr, tx_byte, tx_dv, dc,
    output rom_data, tx_ready
  );
endinterface

// File: rtl/ssd1306_stream_sequencer.sv
// SSD1306 stream sequencer: pulses panel reset, then streams init commands and frame pixels from a
// synchronous ROM to the SPI master. Define SEQ_CONTINUOUS_EN to stream frames endlessly.
module ssd1306_stream_sequencer #(
  parameter int INIT_LEN        = 26,
  parameter int FRAME_BYTES     = 1024,
  parameter int ROM_AW          = 11,
  parameter int RES_LOW_CYCLES  = 16,
  parameter int RES_WAIT_CYCLES = 16
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Start,
  ssd1306_stream_sequencer_if.master bus,
  output logic o_CS_L,
  output logic o_RES_L,
  output logic o_Busy,
  output logic o_Done
`ifdef SEQ_CONTINUOUS_EN
  ,
  output logic [15:0] o_Frame_Cnt
`endif
);

  localparam logic [ROM_AW-1:0] LAST_ADDR     = ROM_AW'(INIT_LEN + FRAME_BYTES - 1);
  localparam logic [ROM_AW-1:0] FIRST_DATA    = ROM_AW'(INIT_LEN);
  localparam logic [15:0]       RES_LOW_LAST  = 16'(RES_LOW_CYCLES - 1);
  localparam logic [15:0]       RES_WAIT_LAST = 16'(RES_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RES_LOW  = 3'd1,
    ST_RES_WAIT = 3'd2,
    ST_FETCH    = 3'd3,
    ST_WAIT_ROM = 3'd4,
    ST_SEND     = 3'd5,
    ST_WAIT_ACK = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_dv_q, tx_dv_d;
  logic              dc_q, dc_d;
  logic              cs_l_q, cs_l_d;
  logic              res_l_q, res_l_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              ack_skip_q, ack_skip_d;
`ifdef SEQ_CONTINUOUS_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
`endif

  // Next-state and registered-output logic; every output is a flop, so values are set on entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    dc_d       = dc_q;
    cs_l_d     = cs_l_q;
    res_l_d    = res_l_q;
    done_d     = 1'b0;
    ack_skip_d = ack_skip_q;
`ifdef SEQ_CONTINUOUS_EN
    frame_cnt_d = frame_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          state_d = ST_RES_LOW;
          res_l_d = 1'b0;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RES_LOW: begin
        if (cnt_q >= RES_LOW_LAST) begin
          state_d = ST_RES_WAIT;
          res_l_d = 1'b1;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RES_WAIT: begin
        if (cnt_q >= RES_WAIT_LAST) begin
          state_d = ST_FETCH;
          cs_l_d  = 1'b0;
          addr_d  = '0;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_FETCH: begin
        dc_d    = (addr_q >= FIRST_DATA);
        state_d = ST_WAIT_ROM;
      end
      ST_WAIT_ROM: begin
        tx_byte_d = bus.rom_data;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          tx_dv_d    = 1'b1;
          ack_skip_d = 1'b1;
          state_d    = ST_WAIT_ACK;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_ACK: begin
        // The master still shows ready on the clock right after DV, so that clock is skipped.
        if (ack_skip_q) begin
          ack_skip_d = 1'b0;
        end else if (bus.tx_ready) begin
          if (addr_q == LAST_ADDR) begin
`ifdef SEQ_CONTINUOUS_EN
            addr_d      = FIRST_DATA;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_FETCH;
`else
            cs_l_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
`endif
          end else begin
            addr_d  = addr_q + ROM_AW'(1);
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      addr_q     <= '0;
      tx_byte_q  <= 8'd0;
      tx_dv_q    <= 1'b0;
      dc_q       <= 1'b0;
      cs_l_q     <= 1'b1;
      res_l_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_skip_q <= 1'b0;
`ifdef SEQ_CONTINUOUS_EN
      frame_cnt_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      dc_q       <= dc_d;
      cs_l_q     <= cs_l_d;
      res_l_q    <= res_l_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
      ack_skip_q <= ack_skip_d;
`ifdef SEQ_CONTINUOUS_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.tx_dv    = tx_dv_q;
  assign bus.dc       = dc_q;
  assign o_CS_L       = cs_l_q;
  assign o_RES_L      = res_l_q;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
`ifdef SEQ_CONTINUOUS_EN
  assign o_Frame_Cnt  = frame_cnt_q;
`endif

endmodule

// File: tb/tb_ssd1306_stream_sequencer.sv
// Directed bench for ssd1306_stream_sequencer: INIT_LEN=3, FRAME_BYTES=4, RES 4/4, ROM[a]=A0+a.
// Define SEQ_CONTINUOUS_EN to exercise the continuous-frame build.
module tb_ssd1306_stream_sequencer;
  localparam int AW = 11;

  logic clk;
  logic rst_n;
  logic start;
  logic ready;
  logic cs_l, res_l, busy, done;
`ifdef SEQ_CONTINUOUS_EN
  logic [15:0] frame_cnt;
`endif

  ssd1306_stream_sequencer_if #(.ROM_AW(AW)) bus ();

  ssd1306_stream_sequencer #(
    .INIT_LEN(3), .FRAME_BYTES(4), .ROM_AW(AW), .RES_LOW_CYCLES(4), .RES_WAIT_CYCLES(4)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .bus(bus),
    .o_CS_L(cs_l), .o_RES_L(res_l), .o_Busy(busy), .o_Done(done)
`ifdef SEQ_CONTINUOUS_EN
    , .o_Frame_Cnt(frame_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_dv = 0;
  int n_done = 0;
  int res_low = 0;
  logic [7:0] byte_log [0:63];
  logic       dc_log   [0:63];
  logic       cs_log   [0:63];
  int         cyc_log  [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.tx_ready = ready;

  always @(posedge clk) bus.rom_data <= 8'hA0 + bus.rom_addr[7:0];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_dv === 1'b1) begin
      if (n_dv < 64) begin
        byte_log[n_dv] = bus.tx_byte;
        dc_log[n_dv]   = bus.dc;
        cs_log[n_dv]   = cs_l;
        cyc_log[n_dv]  = cyc;
      end
      n_dv = n_dv + 1;
    end
    if (res_l === 1'b0) res_low = res_low + 1;
    if (done === 1'b1) n_done = n_done + 1;
  end

  task automatic pulse_start(output int s);
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_dv(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (n_dv >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.rom_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.rom_addr); end
    checks++; if (bus.tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %0h expected 00", bus.tx_byte); end
    checks++; if (bus.tx_dv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %0b expected 0", bus.tx_dv); end
    checks++; if (bus.dc !== 1'b0) begin errors++; $display("FAIL reset_dc: got %0b expected 0", bus.dc); end
    checks++; if (cs_l !== 1'b1) begin errors++; $display("FAIL reset_cs_l: got %0b expected 1", cs_l); end
    checks++; if (res_l !== 1'b1) begin errors++; $display("FAIL reset_res_l: got %0b expected 1", res_l); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
  endtask

`ifndef SEQ_CONTINUOUS_EN
  task automatic test_single_pass;
    int s, b, bd, br;
    bit ok;
    logic [6:0] exp_dc;
    logic [7:0] exp_byte;
    exp_dc = 7'b1111000;
    b = n_dv; bd = n_done; br = res_low;
    ready = 1'b1;
    pulse_start(s);
    wait_done(bd + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pass_timeout: got no done expected done pulse"); end
    repeat (5) @(negedge clk); #1;
    checks++; if (n_dv - b != 7) begin errors++; $display("FAIL pass_count: got %0d expected 7", n_dv - b); end
    for (int i = 0; i < 7; i++) begin
      exp_byte = 8'hA0 + 8'(i);
      checks++; if (byte_log[b+i] !== exp_byte) begin errors++; $display("FAIL pass_byte%0d: got %0h expected %0h", i, byte_log[b+i], exp_byte); end
      checks++; if (dc_log[b+i] !== exp_dc[i]) begin errors++; $display("FAIL pass_dc%0d: got %0b expected %0b", i, dc_log[b+i], exp_dc[i]); end
      checks++; if (cs_log[b+i] !== 1'b0) begin errors++; $display("FAIL pass_cs%0d: got %0b expected 0", i, cs_log[b+i]); end
    end
    // Start sampled at s+1; DV registered RES_LOW+RES_WAIT+3 = 11 edges later.
    checks++; if (cyc_log[b] - s != 12) begin errors++; $display("FAIL pass_latency: got %0d expected 12", cyc_log[b] - s); end
    checks++; if (res_low - br != 4) begin errors++; $display("FAIL pass_res_low: got %0d expected 4", res_low - br); end
    checks++; if (n_done - bd != 1) begin errors++; $display("FAIL pass_done: got %0d expected 1", n_done - bd); end
    checks++; if (cs_l !== 1'b1) begin errors++; $display("FAIL pass_cs_after: got %0b expected 1", cs_l); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_backpressure;
    int s, b, bd, bad;
    bit ok;
    b = n_dv; bd = n_done; bad = 0;
    ready = 1'b1;
    pulse_start(s);
    wait_dv(b + 4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no 4th dv expected dv"); end
    // Ready drops during FETCH of byte A4, so SEND finds it low.
    @(negedge clk); @(negedge clk); #1;
    ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (bus.tx_byte !== 8'hA4) begin errors++; $display("FAIL bp_byte: got %0h expected a4", bus.tx_byte); end
    checks++; if (bus.dc !== 1'b1) begin errors++; $display("FAIL bp_dc: got %0b expected 1", bus.dc); end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); #1;
      if (bus.tx_dv !== 1'b0 || bus.tx_byte !== 8'hA4 || bus.dc !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stall: got %0d bad cycles expected 0", bad); end
    checks++; if (n_dv - b != 4) begin errors++; $display("FAIL bp_no_dv: got %0d expected 4", n_dv - b); end
    ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.tx_dv !== 1'b1) begin errors++; $display("FAIL bp_release_dv: got %0b expected 1", bus.tx_dv); end
    wait_done(bd + 1, ok);
    checks++; if (!ok || n_dv - b != 7) begin errors++; $display("FAIL bp_total: got %0d expected 7", n_dv - b); end
  endtask

  task automatic test_start_ignored;
    int s, t, b, bd;
    bit ok;
    b = n_dv; bd = n_done;
    ready = 1'b1;
    pulse_start(s);
    wait_dv(b + 1, ok);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %0b expected 1", busy); end
    pulse_start(t);
    pulse_start(t);
    wait_done(bd + 1, ok);
    repeat (60) @(negedge clk); #1;
    checks++; if (n_dv - b != 7) begin errors++; $display("FAIL ign_count: got %0d expected 7", n_dv - b); end
    checks++; if (n_done - bd != 1) begin errors++; $display("FAIL ign_done: got %0d expected 1", n_done - bd); end
  endtask
`endif

  task automatic test_reset_mid;
    int s, b;
    bit ok;
    b = n_dv;
    ready = 1'b1;
    pulse_start(s);
    wait_dv(b + 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout: got no 2nd dv expected dv"); end
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.tx_dv !== 1'b0) begin errors++; $display("FAIL mid_dv: got %0b expected 0", bus.tx_dv); end
    checks++; if (cs_l !== 1'b1) begin errors++; $display("FAIL mid_cs_l: got %0b expected 1", cs_l); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    checks++; if (bus.tx_byte !== 8'h00) begin errors++; $display("FAIL mid_byte: got %0h expected 00", bus.tx_byte); end
`ifdef SEQ_CONTINUOUS_EN
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt: got %0d expected 0", frame_cnt); end
`endif
    rst_n = 1'b1;
    repeat (40) @(negedge clk); #1;
    checks++; if (n_dv - b != 2) begin errors++; $display("FAIL mid_abandon: got %0d expected 2", n_dv - b); end
  endtask

`ifdef SEQ_CONTINUOUS_EN
  task automatic test_continuous;
    int s, b, bd, bad;
    bit ok;
    b = n_dv; bd = n_done; bad = 0;
    ready = 1'b1;
    pulse_start(s);
    wait_dv(b + 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_timeout: got %0d dv expected 10", n_dv - b); end
    checks++; if (byte_log[b+6] !== 8'hA6) begin errors++; $display("FAIL cont_last: got %0h expected a6", byte_log[b+6]); end
    checks++; if (byte_log[b+7] !== 8'hA3) begin errors++; $display("FAIL cont_wrap_byte: got %0h expected a3", byte_log[b+7]); end
    checks++; if (dc_log[b+7] !== 1'b1) begin errors++; $display("FAIL cont_wrap_dc: got %0b expected 1", dc_log[b+7]); end
    checks++; if (byte_log[b+9] !== 8'hA5) begin errors++; $display("FAIL cont_byte9: got %0h expected a5", byte_log[b+9]); end
    for (int i = 0; i < 10; i++) if (cs_log[b+i] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL cont_cs: got %0d high expected 0", bad); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL cont_frame_cnt: got %0d expected 1", frame_cnt); end
    checks++; if (n_done != bd) begin errors++; $display("FAIL cont_done: got %0d expected 0", n_done - bd); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy: got %0b expected 1", busy); end
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL cont_frame_rst: got %0d expected 0", frame_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    test_reset;
`ifdef SEQ_CONTINUOUS_EN
    test_continuous;
`else
    test_single_pass;
    test_backpressure;
    test_start_ignored;
`endif
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
